scrambler: RTL and testbench
============================

Name: scrambler

Overview:
- IEEE 802.11a/g data scrambler. Sits directly upstream of the convolutional encoder; its master interface drives the encoder's slave AXI-Stream.
- Each beat, XORs WIDTH data bits with the frame-synchronous sequence from x^7+x^4+1.
- Reloads the 7-bit seed at the first beat of every packet.
- Forces masked bit positions (the 6 tail bits) to zero after scrambling.

Parameters:
- WIDTH, 24, data bits per beat; must be >= 1. Equals the encoder's input width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- seed  in  7  scrambler initial state for the next packet; sampled on the first-beat handshake
- s_axis_tdata  in  WIDTH  plain data; bit 0 is earliest in time
- s_axis_tuser  in  4  rate code; passed through unchanged
- s_axis_tkeep_zero  in  WIDTH  per-bit force-zero mask, applied after scrambling (tail bits)
- s_axis_tvalid  in  1  slave valid
- s_axis_tready  out  1  slave ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  WIDTH  scrambled data
- m_axis_tuser  out  4  registered copy of s_axis_tuser
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- m_axis_tlast  out  1  registered copy of s_axis_tlast

Behaviour:
Reset:
- aresetn low asynchronously clears m_axis_tdata, m_axis_tuser, m_axis_tlast and m_axis_tvalid to 0.
- Reset also clears the LFSR to 7'h00 and sets sop (start-of-packet flag) to 1.
- Reset mid-packet abandons the packet. The next accepted beat is treated as a first beat.

Handshake:
- s_axis_tready = ~m_axis_tvalid | m_axis_tready. This is a single registered stage with no combinational path from s_axis_tvalid to m_axis_tvalid.
- Slave handshake (s_axis_tvalid & s_axis_tready): output registers load, m_axis_tvalid becomes 1 on the next edge. Latency is 1 cycle.
- Master handshake without a slave handshake: m_axis_tvalid becomes 0.
- Master and slave handshakes in the same cycle: new data loads and m_axis_tvalid stays 1.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.

LFSR, per bit:
- State sr[7:1]. For bit i = 0 .. WIDTH-1, in order:
  - fb = sr[7] ^ sr[4]
  - out[i] = (s_axis_tdata[i] ^ fb) & ~s_axis_tkeep_zero[i]
  - sr = {sr[6:1], fb}
- Implement as a WIDTH-deep combinational unroll. The state after WIDTH steps is registered on each slave handshake.
- The mask does not affect the LFSR advance.

Seeding:
- If sop=1 at a slave handshake, the unroll starts from seed instead of the stored sr.
- If seed == 0, use 7'h7F instead. The all-zero state is illegal.
- sop clears on any slave handshake with tlast=0.
- sop sets on a slave handshake with tlast=1. A single-beat packet (sop=1 and tlast=1) uses seed and leaves sop=1.

Other rules:
- The sequence period is 127. Wrap-around is inherent to the LFSR; no special handling.
- The LFSR state is not observable on ports. Verify it through m_axis_tdata only.
- No state machine beyond sop and the valid register.

Test Plan:
1. seed=7'h7F, one beat, tdata=0, mask=0, tlast=1, tuser=4'hB -> one cycle later: m_axis_tdata=24'h934F70, tuser=4'hB, tlast=1.
2. seed=7'h7F, 127 zero beats at WIDTH=24 within one packet -> concatenated output repeats with period 127 bits. Output bits 127..150 equal bits 0..23.
3. seed=0 -> output identical to scenario 1 (seed substituted with 7'h7F).
4. Packet A: 3 beats, seed=7'h7F, tlast on beat 3. Then packet B: 1 beat, seed=7'h5D -> B's output equals a fresh packet seeded with 7'h5D. Proves per-packet reload.
5. tdata=0, seed=7'h7F, mask=24'hFC0000 -> m_axis_tdata=24'h034F70. Next beat identical to an unmasked run (LFSR unaffected by mask).
6. Backpressure: m_axis_tready toggles randomly with continuous s_axis_tvalid -> no beat lost or duplicated, outputs stable while stalled. Assert aresetn low mid-packet -> m_axis_tvalid=0 immediately, the next beat uses seed.

Source files
------------

// File: rtl/scrambler.sv
// ---------------------------------------------------------------------------
// scrambler
//
// IEEE 802.11a/g data scrambler (x^7 + x^4 + 1) with an AXI-Stream slave
// input and a single registered AXI-Stream master output. Each accepted beat
// is XORed bit-by-bit (bit 0 earliest) with the frame-synchronous sequence.
// The 7-bit seed is reloaded on the first beat of each packet, and masked bit
// positions (tail bits) are forced to zero after scrambling.
//
// Parameters:
//   WIDTH              data bits per beat (>= 1)
// Ports:
//   aclk               clock
//   aresetn            asynchronous active-low reset
//   seed               initial LFSR state for the next packet (0 -> 7'h7F)
//   s_axis_tdata       plain data, bit 0 earliest in time
//   s_axis_tuser       rate code, passed through
//   s_axis_tkeep_zero  per-bit force-zero mask applied after scrambling
//   s_axis_tvalid      slave valid
//   s_axis_tready      slave ready
//   s_axis_tlast       last beat of packet
//   m_axis_tdata       scrambled data
//   m_axis_tuser       registered rate code
//   m_axis_tvalid      master valid
//   m_axis_tready      master ready
//   m_axis_tlast       registered last flag
// ---------------------------------------------------------------------------
module scrambler #(
    parameter int WIDTH = 24
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [6:0]       seed,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic [3:0]       s_axis_tuser,
    input  logic [WIDTH-1:0] s_axis_tkeep_zero,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [3:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    // LFSR state, numbered to match the polynomial taps: sr[7] is the oldest bit.
    logic [7:1]       sr;
    logic             sop;
    logic [7:1]       sr_next;
    logic [WIDTH-1:0] scrambled;
    logic             s_hs;

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign s_hs          = s_axis_tvalid & s_axis_tready;

    // WIDTH-deep unroll of the serial scrambler. The first beat of a packet
    // starts from the (non-zero) seed instead of the stored state.
    always_comb begin
        logic [7:1] st;
        logic       fb;
        scrambled = '0;
        fb        = 1'b0;
        if (sop) begin
            st = (seed == 7'h00) ? 7'h7F : seed;
        end else begin
            st = sr;
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            fb           = st[7] ^ st[4];
            scrambled[i] = (s_axis_tdata[i] ^ fb) & ~s_axis_tkeep_zero[i];
            st           = {st[6:1], fb};
        end
        sr_next = st;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr            <= '0;
            sop           <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (s_hs) begin
            sr            <= sr_next;
            // Next beat starts a new packet exactly when this one was last.
            sop           <= s_axis_tlast;
            m_axis_tdata  <= scrambled;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scrambler.sv
module tb_scrambler;

    localparam int W = 24;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [6:0]   seed = '0;
    logic [W-1:0] s_data = '0;
    logic [3:0]   s_user = '0;
    logic [W-1:0] s_mask = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_last = 1'b0;
    logic [W-1:0] m_data;
    logic [3:0]   m_user;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         m_last;

    scrambler #(.WIDTH(W)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .seed              (seed),
        .s_axis_tdata      (s_data),
        .s_axis_tuser      (s_user),
        .s_axis_tkeep_zero (s_mask),
        .s_axis_tvalid     (s_valid),
        .s_axis_tready     (s_ready),
        .s_axis_tlast      (s_last),
        .m_axis_tdata      (m_data),
        .m_axis_tuser      (m_user),
        .m_axis_tvalid     (m_valid),
        .m_axis_tready     (m_ready),
        .m_axis_tlast      (m_last)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   user;
        logic         last;
    } beat_t;

    int unsigned tests = 0;
    int unsigned fails = 0;
    bit          rand_mode = 0;

    beat_t        sb[$];
    logic [W-1:0] obs[$];

    // Reference: keystream ks[n] = ks[n-7] ^ ks[n-4], ks[0..6] = seed (MSB first).
    bit           ks[$];
    int unsigned  kpos;
    bit           msop = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_beat(input logic [W-1:0] d, input logic [W-1:0] mk,
                              input logic [3:0] u, input logic l, input logic [6:0] sd);
        beat_t b;
        logic [6:0] s;
        int unsigned idx;
        if (msop) begin
            ks.delete();
            s = (sd == 7'h00) ? 7'h7F : sd;
            for (int j = 0; j < 7; j++) ks.push_back(s[6-j]);
            kpos = 0;
        end
        for (int i = 0; i < W; i++) begin
            idx = kpos + 7;
            while (ks.size() <= idx) ks.push_back(ks[ks.size()-7] ^ ks[ks.size()-4]);
            b.data[i] = (d[i] ^ ks[idx]) & ~mk[i];
            kpos++;
        end
        b.user = u;
        b.last = l;
        msop = l;
        sb.push_back(b);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one beat and hold it until it is accepted; s_valid stays high.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] mk,
                        input logic [3:0] u, input logic l, input logic [6:0] sd);
        bit done = 0;
        s_valid = 1'b1; s_data = d; s_mask = mk; s_user = u; s_last = l; seed = sd;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge aclk);
            if (s_ready) begin
                model_beat(d, mk, u, l, sd);
                done = 1;
            end
            step();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        rand_mode = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    // Scoreboard compare on every master handshake.
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn && m_valid && m_ready) begin
            obs.push_back(m_data);
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("tdata", 32'(m_data), 32'(e.data));
                check("tuser", 32'(m_user), 32'(e.user));
                check("tlast", 32'(m_last), 32'(e.last));
            end
        end
    end

    // Outputs must hold while stalled.
    logic         stalled = 0;
    logic [W+4:0] held;
    always @(negedge aclk) begin
        if (!aresetn) begin
            stalled <= 0;
        end else begin
            if (stalled) check("stall_hold", 32'({m_data, m_user, m_last}), 32'(held));
            stalled <= m_valid && !m_ready;
            held    <= {m_data, m_user, m_last};
        end
    end

    initial begin
        logic [W-1:0] cat;
        int unsigned  start;
        int unsigned  b;

        // Reset state
        #12;
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_user", 32'(m_user), 0);
        check("rst_last", 32'(m_last), 0);
        aresetn = 1'b1;
        step();

        // 1: single beat, all-ones seed
        send('0, '0, 4'hB, 1'b1, 7'h7F);
        drain();
        check("s1_const", 32'(obs[obs.size()-1]), 32'h934F70);

        // 3: seed 0 substitutes 7'h7F
        send('0, '0, 4'h3, 1'b1, 7'h00);
        drain();
        check("s3_seed0", 32'(obs[obs.size()-1]), 32'h934F70);

        // 2: period 127 over a 127-beat packet
        start = obs.size();
        for (int k = 0; k < 127; k++) send('0, '0, 4'h1, (k == 126), 7'h7F);
        drain();
        for (int k = 0; k < W; k++) begin
            b = 127 + k;
            cat[k] = obs[start + b / W][b % W];
        end
        check("s2_period", 32'(cat), 32'h934F70);

        // 4: per-packet reload
        for (int k = 0; k < 3; k++) send(W'($urandom), '0, 4'h5, (k == 2), 7'h7F);
        send(24'hA5C3F0, '0, 4'h6, 1'b1, 7'h5D);
        drain();
        send(24'hA5C3F0, '0, 4'h6, 1'b1, 7'h5D);
        drain();
        check("s4_reload", 32'(obs[obs.size()-1]), 32'(obs[obs.size()-2]));

        // 5: tail mask, LFSR unaffected
        send('0, 24'hFC0000, 4'h2, 1'b0, 7'h7F);
        send('0, '0, 4'h2, 1'b1, 7'h7F);
        drain();
        check("s5_mask", 32'(obs[obs.size()-2]), 32'h034F70);

        // 6: random backpressure with continuous valid
        rand_mode = 1;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++)
                send(W'($urandom), W'($urandom) & 24'h00000F, 4'(p), (k == 7), 7'(p * 19 + 3));
        drain();

        // 6b: reset mid-packet
        send(24'h123456, '0, 4'h7, 1'b0, 7'h11);
        send(24'h654321, '0, 4'h7, 1'b0, 7'h11);
        s_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid), 0);
        check("midrst_data", 32'(m_data), 0);
        sb.delete();
        msop = 1;
        step();
        aresetn = 1'b1;
        step();
        send('0, '0, 4'h9, 1'b1, 7'h7F);
        drain();
        check("midrst_seed", 32'(obs[obs.size()-1]), 32'h934F70);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
